// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and the function-under-test / result consumer.
interface truth_table_scanner_if #(
    parameter int unsigned N_IN = 5
);
    localparam int unsigned TBL_W  = 1 << N_IN;
    localparam int unsigned ONES_W = N_IN + 1;

    logic              start;
    logic              fn_in;
    logic [N_IN-1:0]   vec;
    logic              busy;
    logic              done;
    logic [TBL_W-1:0]  tbl;
    logic [ONES_W-1:0] ones;

    // Environment side: requests scans, returns fn_in, reads results.
    modport master (
        output start,
        output fn_in,
        input  vec,
        input  busy,
        input  done,
        input  tbl,
        input  ones
    );

    // Scanner side.
    modport slave (
        input  start,
        input  fn_in,
        output vec,
        output busy,
        output done,
        output tbl,
        output ones
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input combination through an external combinational function,
// holding each vector SETTLE+1 cycles, and records the full truth table
// (bus.tbl, bit k = output for vector k) plus the minterm count.
module truth_table_scanner #(
    parameter int unsigned N_IN   = 5,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_scanner_if.slave  bus
);
    localparam int unsigned VEC_W  = N_IN;
    localparam int unsigned TBL_W  = 1 << N_IN;
    localparam int unsigned ONES_W = N_IN + 1;
    localparam int unsigned HOLD_W = 4;

    localparam logic [VEC_W-1:0]  VEC_LAST   = {VEC_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_CLOSE = HOLD_W'(SETTLE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    vec_q,   vec_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [TBL_W-1:0]    tbl_q,   tbl_d;
    logic [ONES_W-1:0]   ones_q,  ones_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            tbl_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            tbl_q   <= tbl_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: sample fn_in only at the closing edge of each hold window.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        tbl_d   = tbl_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                vec_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    tbl_d   = '0;
                    ones_d  = '0;
                end
            end

            ST_SCAN: begin
                if (hold_q == HOLD_CLOSE) begin
                    tbl_d[vec_q] = bus.fn_in;
                    ones_d       = ones_q + ONES_W'(bus.fn_in);
                    hold_d       = '0;
                    if (vec_q == VEC_LAST) begin
                        // Last vector sampled: finish without letting vec wrap.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.vec  = vec_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tbl  = tbl_q;
    assign bus.ones = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: three scanner instances (N_IN/SETTLE = 3/1, 3/0, 5/2),
// each wrapped around a small reference boolean function.
module tb_truth_table_scanner;

    logic clk;
    logic rst_n;
    logic start_r;
    int   dsel;
    bit   fn_sel;
    bit   tie_val;

    int n_vec  = 0;
    int n_miss = 0;

    truth_table_scanner_if #(.N_IN(3)) bus_a ();
    truth_table_scanner_if #(.N_IN(3)) bus_b ();
    truth_table_scanner_if #(.N_IN(5)) bus_c ();

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    truth_table_scanner #(.N_IN(3), .SETTLE(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    truth_table_scanner #(.N_IN(5), .SETTLE(2)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // A&~B&C | ~A&B&~C | A&B&C
    function automatic logic f1(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (a & ~b & c) | (~a & b & ~c) | (a & b & c);
    endfunction

    // (A|B|C)&(~A|~B|~C)&(A|~B|C)
    function automatic logic f2(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (a | b | c) & (~a | ~b | ~c) & (a | ~b | c);
    endfunction

    assign bus_a.start = start_r && (dsel == 0);
    assign bus_b.start = start_r && (dsel == 1);
    assign bus_c.start = start_r && (dsel == 2);

    assign bus_a.fn_in = fn_sel ? f2(bus_a.vec) : f1(bus_a.vec);
    assign bus_b.fn_in = tie_val;
    assign bus_c.fn_in = (bus_c.vec == 5'd0) || (bus_c.vec == 5'd31);

    logic        done_m;
    logic        busy_m;
    logic [4:0]  vec_m;
    logic [31:0] tbl_m;
    logic [5:0]  ones_m;

    // Observe the currently selected instance.
    always_comb begin
        done_m = 1'b0;
        busy_m = 1'b0;
        vec_m  = '0;
        tbl_m  = '0;
        ones_m = '0;
        case (dsel)
            0: begin
                done_m = bus_a.done; busy_m = bus_a.busy; vec_m = 5'(bus_a.vec);
                tbl_m  = 32'(bus_a.tbl); ones_m = 6'(bus_a.ones);
            end
            1: begin
                done_m = bus_b.done; busy_m = bus_b.busy; vec_m = 5'(bus_b.vec);
                tbl_m  = 32'(bus_b.tbl); ones_m = 6'(bus_b.ones);
            end
            default: begin
                done_m = bus_c.done; busy_m = bus_c.busy; vec_m = bus_c.vec;
                tbl_m  = bus_c.tbl;  ones_m = bus_c.ones;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    // lat = cycles from the accepting edge to the done cycle.
    task automatic run_scan(input int max_k, input bit hold, input int poke_k,
                            output int lat, output int busy_cnt);
        int k;
        lat      = -1;
        busy_cnt = 0;
        k        = 0;
        start_r  = 1'b1;
        @(negedge clk);
        while (k <= max_k) begin
            start_r = hold || (k == poke_k);
            if (done_m) begin
                lat = k;
                break;
            end
            busy_cnt += int'(busy_m);
            k++;
            @(negedge clk);
        end
    endtask

    // Cycles from the current negedge to the next done pulse.
    task automatic wait_done(input int max_k, output int lat);
        int k;
        k   = 0;
        lat = -1;
        do begin
            @(negedge clk);
            k++;
            if (done_m) begin
                lat = k;
                break;
            end
        end while (k < max_k);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;

        rst_n   = 1'b0;
        start_r = 1'b0;
        dsel    = 0;
        fn_sel  = 1'b0;
        tie_val = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy_a", 64'(bus_a.busy), 64'd0);
        check("rst_done_a", 64'(bus_a.done), 64'd0);
        check("rst_vec_a",  64'(bus_a.vec),  64'd0);
        check("rst_tbl_a",  64'(bus_a.tbl),  64'd0);
        check("rst_ones_a", 64'(bus_a.ones), 64'd0);
        check("rst_tbl_c",  64'(bus_c.tbl),  64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // f1, N_IN=3, SETTLE=1
        dsel = 0; fn_sel = 1'b0;
        run_scan(40, 1'b0, -1, lat, bcnt);
        check("f1_latency", 64'(lat),    64'd16);
        check("f1_busy",    64'(bcnt),   64'd16);
        check("f1_tbl",     64'(tbl_m),  64'hA4);
        check("f1_ones",    64'(ones_m), 64'd3);
        check("f1_busy_dn", 64'(busy_m), 64'd0);
        check("f1_vec_dn",  64'(vec_m),  64'd0);
        @(negedge clk);
        check("f1_done_1c", 64'(done_m), 64'd0);

        // f2, with a stray start pulse at cycle 5 of the scan
        fn_sel = 1'b1;
        repeat (2) @(negedge clk);
        run_scan(40, 1'b0, 5, lat, bcnt);
        check("f2_latency", 64'(lat),    64'd16);
        check("f2_tbl",     64'(tbl_m),  64'h7A);
        check("f2_ones",    64'(ones_m), 64'd5);
        repeat (4) @(negedge clk);
        check("f2_hold_tbl",  64'(tbl_m),  64'h7A);
        check("f2_hold_ones", 64'(ones_m), 64'd5);
        check("f2_idle_busy", 64'(busy_m), 64'd0);

        // start held high: back-to-back scans every 17 cycles
        fn_sel = 1'b0;
        run_scan(40, 1'b1, -1, lat, bcnt);
        check("held_lat1", 64'(lat), 64'd16);
        wait_done(40, lat);
        start_r = 1'b0;
        check("held_period", 64'(lat),    64'd17);
        check("held_tbl",    64'(tbl_m),  64'hA4);
        check("held_ones",   64'(ones_m), 64'd3);
        @(negedge clk);
        check("held_release_idle", 64'(busy_m), 64'd0);

        // N_IN=3, SETTLE=0, fn tied 0 then 1
        dsel = 1; tie_val = 1'b0;
        repeat (2) @(negedge clk);
        run_scan(20, 1'b0, -1, lat, bcnt);
        check("tie0_latency", 64'(lat),    64'd8);
        check("tie0_tbl",     64'(tbl_m),  64'h00);
        check("tie0_ones",    64'(ones_m), 64'd0);
        tie_val = 1'b1;
        repeat (2) @(negedge clk);
        run_scan(20, 1'b0, -1, lat, bcnt);
        check("tie1_latency", 64'(lat),    64'd8);
        check("tie1_busy",    64'(bcnt),   64'd8);
        check("tie1_tbl",     64'(tbl_m),  64'hFF);
        check("tie1_ones",    64'(ones_m), 64'd8);

        // N_IN=5, SETTLE=2, minterms 0 and 31
        dsel = 2;
        repeat (2) @(negedge clk);
        run_scan(200, 1'b0, -1, lat, bcnt);
        check("n5_latency", 64'(lat),    64'd96);
        check("n5_busy",    64'(bcnt),   64'd96);
        check("n5_tbl",     64'(tbl_m),  64'h8000_0001);
        check("n5_ones",    64'(ones_m), 64'd2);

        // Asynchronous reset in cycle 7 of an f1 scan
        dsel = 0; fn_sel = 1'b0;
        repeat (2) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy_m), 64'd1);
        check("pre_rst_vec",  64'(vec_m),  64'd3);
        check("pre_rst_tbl",  64'(tbl_m),  64'h04);
        check("pre_rst_ones", 64'(ones_m), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy_m), 64'd0);
        check("arst_vec",  64'(vec_m),  64'd0);
        check("arst_tbl",  64'(tbl_m),  64'd0);
        check("arst_ones", 64'(ones_m), 64'd0);
        check("arst_done", 64'(done_m), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            dcnt += int'(done_m);
            bcnt += int'(busy_m);
        end
        check("post_rst_no_done", 64'(dcnt), 64'd0);
        check("post_rst_idle",    64'(bcnt), 64'd0);
        check("post_rst_tbl",     64'(tbl_m), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential inverse of a combinational boolean block: drives every input combination onto a function-under-test and reads its 1-bit output back.
- Produces the complete truth table plus the minterm count.
- Used on the lab board to extract the truth tables of the TP2 gate-level functions and compare them against hand-derived or Karnaugh-reduced forms.
- The function-under-test sits outside this block, between vec and fn_in.

Parameters:
- N_IN, 5, number of function inputs; legal range 1..6. vec[N_IN-1] is the most significant input ("A").
- SETTLE, 1, extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only.
- fn_in  in  1  output of the function-under-test.
- vec  out  N_IN  input vector driven to the function-under-test.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- table  out  2**N_IN  table[k] = fn_in sampled while vec==k.
- ones  out  N_IN+1  number of k with table[k]==1.

Behaviour:
- Reset: rst_n low forces IDLE immediately (asynchronous) with vec=0, busy=0, done=0, table=0, ones=0.
- Reset mid-scan aborts the scan; no done pulse is issued; the scan does not resume after rst_n rises.
- States: IDLE, SCAN. SETTLE is handled by a hold counter inside SCAN.
- IDLE behaviour:
  - vec=0, busy=0; table and ones hold the last result.
  - start=1 at edge E0 moves to SCAN and sets busy=1, vec=0, table=0, ones=0, hold counter=0.
- SCAN behaviour:
  - Vector k is driven for exactly SETTLE+1 cycles, from edge E0+k*(SETTLE+1) to edge E0+(k+1)*(SETTLE+1).
  - fn_in is sampled only at the closing edge of that window: table[k] <= fn_in, and ones <= ones+fn_in.
  - Then vec <= k+1 and the hold counter is cleared.
- Completion:
  - At the closing edge of the window for k = 2**N_IN-1: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle, vec <= 0.
  - The table and ones registers include the final sample in that same edge.
- Latency: done is high in the cycle starting at edge E0 + 2**N_IN*(SETTLE+1). For N_IN=3 and SETTLE=1 that is 16 cycles after start is accepted.
- start during SCAN is ignored and never restarts the scan.
- start=1 in the done cycle is accepted at the next edge. A start held continuously gives back-to-back scans with one IDLE cycle between them.
- Accepting a new start clears table and ones, so results are valid from the done pulse until the next accepted start.
- Width rules:
  - vec wrap from 2**N_IN-1 never reaches the outputs, because the scan ends there.
  - ones reaches 2**N_IN without overflow since it is N_IN+1 bits wide.
- fn_in is assumed combinationally driven from vec. The block does not synchronise fn_in; with SETTLE=0 the combinational path vec->fn_in must meet one clock period.

Test Plan:
- N_IN=3, SETTLE=1, fn_in = A&~B&C | ~A&B&~C | A&B&C with A=vec[2], C=vec[0]; pulse start -> done 16 cycles later, table=8'hA4, ones=3, busy high for exactly 16 cycles.
- Same setup, fn_in = (A|B|C)&(~A|~B|~C)&(A|~B|C) -> table=8'h7A, ones=5.
- N_IN=3, SETTLE=0, fn_in tied 0, then tied 1 -> table=8'h00 with ones=0, then table=8'hFF with ones=8; done 8 cycles after start in each case.
- Start pulsed again at cycle 5 of a scan -> ignored; done still arrives at cycle 16 with correct table. Start held high continuously -> done pulses every 17 cycles.
- rst_n asserted at cycle 7 of a scan, asynchronously mid-cycle -> outputs go to 0 immediately with no clock edge needed; no done pulse; after release the block stays IDLE until start.
- N_IN=5, SETTLE=2, fn_in = vec==5'd0 | vec==5'd31 -> done 96 cycles after start, table=32'h8000_0001, ones=2.
